// File: rtl/qft3_measure_unit.sv
// qft3_measure_unit: streams |amp|^2 per basis state of a 3-qubit QFT result and reports the argmax; define QFT3_MEAS_NORM_CHECK_EN to enable the normalisation check
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif
module qft3_measure_unit #(
  parameter int LATENCY  = 19,
  parameter int NORM_TOL = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    launch,
  input  logic [`TOTAL_WIDTH-1:0] f000_r,
  input  logic [`TOTAL_WIDTH-1:0] f000_i,
  input  logic [`TOTAL_WIDTH-1:0] f001_r,
  input  logic [`TOTAL_WIDTH-1:0] f001_i,
  input  logic [`TOTAL_WIDTH-1:0] f010_r,
  input  logic [`TOTAL_WIDTH-1:0] f010_i,
  input  logic [`TOTAL_WIDTH-1:0] f011_r,
  input  logic [`TOTAL_WIDTH-1:0] f011_i,
  input  logic [`TOTAL_WIDTH-1:0] f100_r,
  input  logic [`TOTAL_WIDTH-1:0] f100_i,
  input  logic [`TOTAL_WIDTH-1:0] f101_r,
  input  logic [`TOTAL_WIDTH-1:0] f101_i,
  input  logic [`TOTAL_WIDTH-1:0] f110_r,
  input  logic [`TOTAL_WIDTH-1:0] f110_i,
  input  logic [`TOTAL_WIDTH-1:0] f111_r,
  input  logic [`TOTAL_WIDTH-1:0] f111_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_idx,
  output logic [15:0]             out_prob,
  output logic                    max_valid,
  output logic [2:0]              max_idx,
  output logic [15:0]             max_prob,
  output logic                    busy,
  output logic                    drop_err,
  output logic [18:0]             norm_sum,
  output logic                    norm_err
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [LATENCY-1:0] pipe_sr;
  logic [`TOTAL_WIDTH-1:0] in_r [8];
  logic [`TOTAL_WIDTH-1:0] in_i [8];
  logic [`TOTAL_WIDTH-1:0] cap_r [8];
  logic [`TOTAL_WIDTH-1:0] cap_i [8];
  logic [2:0] idx;
  logic arrival, cap, hs, last, upd;
  logic signed [15:0] ext_r, ext_i;
  logic [15:0] prob, run_max, new_max;
  logic [2:0] run_idx, new_idx;
  assign in_r = '{f000_r, f001_r, f010_r, f011_r, f100_r, f101_r, f110_r, f111_r};
  assign in_i = '{f000_i, f001_i, f010_i, f011_i, f100_i, f101_i, f110_i, f111_i};
  assign arrival = pipe_sr[LATENCY-1];
  assign cap = (state_q == IDLE) && arrival;
  assign out_valid = (state_q == STREAM);
  assign busy = (state_q != IDLE);
  assign hs = out_valid && out_ready;
  assign last = hs && (idx == 3'd7);
  assign out_idx = idx;
  // Sign-extend before squaring so (-128,-128) yields the full 32768 in 16 unsigned bits
  assign ext_r = 16'($signed(cap_r[idx]));
  assign ext_i = 16'($signed(cap_i[idx]));
  assign prob = ext_r * ext_r + ext_i * ext_i;
  assign out_prob = out_valid ? prob : 16'd0;
  // Index 0 seeds the running max; strict compare keeps the lower index on ties
  assign upd = (idx == 3'd0) || (prob > run_max);
  assign new_max = upd ? prob : run_max;
  assign new_idx = upd ? idx : run_idx;
  // Next state: capture from IDLE on arrival, return after the index-7 handshake
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (arrival ? STREAM : IDLE) : (last ? IDLE : STREAM);
  end
  // Launch tracker, FSM state and captured amplitude buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_sr <= '0;
      state_q <= IDLE;
      cap_r <= '{default: '0};
      cap_i <= '{default: '0};
    end else begin
      pipe_sr <= {pipe_sr[LATENCY-2:0], launch};
      state_q <= state_d;
      if (cap) begin
        cap_r <= in_r;
        cap_i <= in_i;
      end
    end
  end
  // Beat index, running argmax and the frame-end max report
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 3'd0;
      run_max <= 16'd0;
      run_idx <= 3'd0;
      max_valid <= 1'b0;
      max_idx <= 3'd0;
      max_prob <= 16'd0;
    end else begin
      max_valid <= last;
      if (hs) begin
        idx <= idx + 3'd1;
        run_max <= new_max;
        run_idx <= new_idx;
      end
      if (last) begin
        max_idx <= new_idx;
        max_prob <= new_max;
      end
    end
  end
  // Sticky flag for arrivals that land while a frame is still streaming
  always_ff @(posedge clk) begin
    if (rst) drop_err <= 1'b0;
    else if (arrival && state_q == STREAM) drop_err <= 1'b1;
  end
`ifdef QFT3_MEAS_NORM_CHECK_EN
  logic [18:0] acc_next;
  logic signed [31:0] dev;
  assign acc_next = norm_sum + 19'(prob);
  assign dev = $signed({13'd0, acc_next}) - 32'sd256;
  // Accumulate handshaken probabilities; judge the total against 256 at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      norm_sum <= 19'd0;
      norm_err <= 1'b0;
    end else begin
      if (cap) norm_sum <= 19'd0;
      else if (hs) norm_sum <= acc_next;
      if (last) norm_err <= (dev > NORM_TOL) || (dev < -NORM_TOL);
    end
  end
`else
  assign norm_sum = 19'd0;
  assign norm_err = 1'b0;
`endif
endmodule

// File: tb/tb_qft3_measure_unit.sv
// tb_qft3_measure_unit: randomized frames checked against a per-frame probability/argmax model
module tb_qft3_measure_unit;
  localparam int LAT = 19;
  localparam int TOL = 64;
  logic clk = 1'b0, rst = 1'b1, launch = 1'b0, out_ready = 1'b0;
  logic [7:0] fr [8];
  logic [7:0] fi [8];
  logic out_valid, max_valid, busy, drop_err, norm_err;
  logic [2:0] out_idx, max_idx;
  logic [15:0] out_prob, max_prob;
  logic [18:0] norm_sum;
  int total = 0, bad = 0;
  int m_r [8];
  int m_i [8];
  int vc;

  qft3_measure_unit #(.LATENCY(LAT), .NORM_TOL(TOL)) dut (
    .clk(clk), .rst(rst), .launch(launch),
    .f000_r(fr[0]), .f000_i(fi[0]), .f001_r(fr[1]), .f001_i(fi[1]),
    .f010_r(fr[2]), .f010_i(fi[2]), .f011_r(fr[3]), .f011_i(fi[3]),
    .f100_r(fr[4]), .f100_i(fi[4]), .f101_r(fr[5]), .f101_i(fi[5]),
    .f110_r(fr[6]), .f110_i(fi[6]), .f111_r(fr[7]), .f111_i(fi[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_prob(out_prob),
    .max_valid(max_valid), .max_idx(max_idx), .max_prob(max_prob),
    .busy(busy), .drop_err(drop_err), .norm_sum(norm_sum), .norm_err(norm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_prob"}, out_prob, 0);
    check({tag, "_mvalid"}, max_valid, 0);
    check({tag, "_midx"}, max_idx, 0);
    check({tag, "_mprob"}, max_prob, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop"}, drop_err, 0);
    check({tag, "_nsum"}, norm_sum, 0);
    check({tag, "_nerr"}, norm_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    launch = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // kind: 0 full-range random, 1 small random (ties likely), 2 rotating +-6 pattern, 3 f011=16, 4 f000=-128-128j, 5 zeros
  task automatic set_pattern(input int kind);
    for (int k = 0; k < 8; k++) begin
      case (kind)
        0: begin m_r[k] = int'($urandom_range(0, 255)) - 128; m_i[k] = int'($urandom_range(0, 255)) - 128; end
        1: begin m_r[k] = int'($urandom_range(0, 4)) - 2; m_i[k] = int'($urandom_range(0, 4)) - 2; end
        2: begin
          m_r[k] = (k % 4 == 0) ? 6 : (k % 4 == 2) ? -6 : 0;
          m_i[k] = (k % 4 == 1) ? -6 : (k % 4 == 3) ? 6 : 0;
        end
        3: begin m_r[k] = (k == 3) ? 16 : 0; m_i[k] = 0; end
        4: begin m_r[k] = (k == 0) ? -128 : 0; m_i[k] = (k == 0) ? -128 : 0; end
        default: begin m_r[k] = 0; m_i[k] = 0; end
      endcase
    end
  endtask

  task automatic drive_f();
    for (int k = 0; k < 8; k++) begin
      fr[k] = 8'(m_r[k]);
      fi[k] = 8'(m_i[k]);
    end
  endtask

  // Launch now, present the frame at the arrival edge; returns at the negedge after capture
  task automatic launch_and_drive();
    @(negedge clk);
    launch = 1'b1;
    @(posedge clk);
    @(negedge clk);
    launch = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    drive_f();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode: 0 always ready, 1 random ready, 2 three stall cycles at index 2
  task automatic collect(input int mode, output int vcyc);
    int pr [8];
    int mi, sum, nerr, exp_idx, stall;
    bit rd, done;
    sum = 0;
    mi = 0;
    for (int k = 0; k < 8; k++) begin
      pr[k] = m_r[k] * m_r[k] + m_i[k] * m_i[k];
      sum += pr[k];
      if (pr[k] > pr[mi]) mi = k;
    end
    nerr = ((sum - 256 > TOL) || (256 - sum > TOL)) ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      fr[k] = 8'($urandom);
      fi[k] = 8'($urandom);
    end
    exp_idx = 0;
    stall = 0;
    vcyc = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      check("beat_valid", out_valid, 1);
      check("beat_busy", busy, 1);
      check("beat_idx", out_idx, exp_idx);
      check("beat_prob", out_prob, pr[exp_idx]);
      check("beat_mvalid", max_valid, 0);
      vcyc++;
      if (mode == 0) rd = 1'b1;
      else if (mode == 1) rd = 1'($urandom_range(0, 1));
      else if (exp_idx == 2 && stall < 3) begin rd = 1'b0; stall++; end
      else rd = 1'b1;
      out_ready = rd;
      if (rd) exp_idx++;
      @(posedge clk);
      @(negedge clk);
      if (exp_idx == 8) done = 1'b1;
    end
    check("stream_timeout", int'(done), 1);
    out_ready = 1'b0;
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
    check("end_mvalid", max_valid, 1);
    check("end_midx", max_idx, mi);
    check("end_mprob", max_prob, pr[mi]);
`ifdef QFT3_MEAS_NORM_CHECK_EN
    check("end_nsum", norm_sum, sum);
    check("end_nerr", norm_err, nerr);
`else
    check("end_nsum", norm_sum, 0);
    check("end_nerr", norm_err, 0);
`endif
    @(negedge clk);
    check("pulse_mvalid", max_valid, 0);
    check("hold_midx", max_idx, mi);
    check("hold_mprob", max_prob, pr[mi]);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      fr[k] = 8'd0;
      fi[k] = 8'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst");
    set_pattern(2);
    launch_and_drive();
    collect(0, vc);
    check("straight_cycles", vc, 8);
    set_pattern(2);
    launch_and_drive();
    collect(2, vc);
    check("stall_cycles", vc, 11);
    for (int p = 3; p <= 5; p++) begin
      set_pattern(p);
      launch_and_drive();
      collect(0, vc);
    end
    for (int n = 0; n < 10; n++) begin
      set_pattern(int'($urandom_range(0, 1)));
      launch_and_drive();
      collect(1, vc);
    end
    // Second launch three cycles behind the first must be dropped while stalled
    set_pattern(0);
    @(negedge clk);
    launch = 1'b1;
    @(posedge clk);
    @(negedge clk);
    launch = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    launch = 1'b1;
    @(posedge clk);
    @(negedge clk);
    launch = 1'b0;
    repeat (LAT - 4) @(posedge clk);
    @(negedge clk);
    drive_f();
    @(posedge clk);
    @(negedge clk);
    check("drop_cap_valid", out_valid, 1);
    check("drop_before", drop_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drop_before2", drop_err, 0);
    @(posedge clk);
    @(negedge clk);
    check("drop_set", drop_err, 1);
    check("drop_idx_held", out_idx, 0);
    collect(0, vc);
    repeat (4) @(negedge clk);
    check("drop_no_frame", out_valid, 0);
    check("drop_sticky", drop_err, 1);
    do_reset();
    check("drop_cleared", drop_err, 0);
    // Reset in the middle of a frame
    set_pattern(0);
    launch_and_drive();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_idx != 3'd4; c++) @(negedge clk);
    check("mid_idx", out_idx, 4);
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrst");
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("midrst_nomax", max_valid, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
